mini_calc_3: RTL and testbench

MINI_CALC_3 -- requirements
Module: mini_calc_3

---
 rtl/mini_calc_3_pkg.sv | 36 +++
 rtl/mini_calc_3_bcd.sv | 69 ++++++
 rtl/mini_calc_3.sv | 223 ++++++++++++++++++++++
 tb/tb_mini_calc_3.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_calc_3_pkg.sv
// Shared types and command bytes for the mini_calc_3 counter/calculator.
// Query support (ST_QWAIT/ST_QSEND) exists only with MINI_CALC_3_QUERY_EN.
package mini_calc_3_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1
`ifdef MINI_CALC_3_QUERY_EN
    ,
    ST_QWAIT = 2'd2,
    ST_QSEND = 2'd3
`endif
  } state_e;

  localparam logic [7:0] CMD_S  = 8'h53;
  localparam logic [7:0] CMD_U  = 8'h55;
  localparam logic [7:0] CMD_D  = 8'h44;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] CMD_L  = 8'h4C;
  localparam logic [7:0] CMD_Q  = 8'h51;
  localparam logic [7:0] CMD_CR = 8'h0D;
  localparam logic [7:0] CMD_LF = 8'h0A;

  function automatic logic [7:0] to_ascii(
    input logic [3:0] d
  );
    return {4'h3, d};
  endfunction

endpackage

// File: rtl/mini_calc_3_bcd.sv
// Free-running double-dabble converter: one load cycle then
// DATA_WIDTH shift cycles; bcd and a done pulse publish together.
module mini_calc_3_bcd #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int NW = $clog2(DATA_WIDTH + 1);

  logic                  busy_q;
  logic [NW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [BW-1:0]         acc_q;
  logic [BW-1:0]         adj;
  logic [BW-1:0]         nxt;
  logic                  done_q;
  logic [BW-1:0]         bcd_q;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    nxt = {adj[BW-2:0], sh_q[DATA_WIDTH-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          busy_q <= 1'b1;
          cnt_q  <= NW'(DATA_WIDTH);
          sh_q   <= bin;
          acc_q  <= '0;
        end
      end else begin
        acc_q <= nxt;
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == NW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          bcd_q  <= nxt;
        end
      end
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/mini_calc_3.sv
// Command-driven up/down counter with decimal load and BCD readout.
// Define MINI_CALC_3_QUERY_EN to enable the 'Q' ASCII query response.
module mini_calc_3
  import mini_calc_3_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_VALUE  = 9999,
  parameter int WRAP       = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic [7:0]            RxData,
  input  logic                  RxValid,
  output logic                  RxReady,
  output logic [7:0]            TxData,
  output logic                  TxValid,
  input  logic                  TxReady,
  output logic [DATA_WIDTH-1:0] Value,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic [1:0]            Mode,
  output logic                  LimitReached
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [DATA_WIDTH-1:0] MAXV =
    DATA_WIDTH'(MAX_VALUE);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         ndig_q, ndig_d;
  logic                  commit_q, commit_d;
  logic [DATA_WIDTH-1:0] cval_q, cval_d;
  logic                  lim_q, lim_d;
  logic                  rdy_q, rdy_d;
  logic                  ld_win;
  logic                  rx_fire;
  logic                  is_dig;
  logic                  cv_done;

  assign rx_fire = RxValid && rdy_q;
  assign is_dig  = (RxData >= 8'h30) && (RxData <= 8'h39);

  mini_calc_3_bcd #(
    .DATA_WIDTH(DATA_WIDTH),
    .DIGITS    (DIGITS)
  ) u_bcd (
    .clk  (Clk),
    .rst_n(Reset),
    .start(1'b1),
    .bin  (value_q),
    .done (cv_done),
    .bcd  (Bcd)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    value_d  = value_q;
    acc_d    = acc_q;
    ndig_d   = ndig_q;
    cval_d   = cval_q;
    commit_d = 1'b0;
    lim_d    = 1'b0;
    ld_win   = 1'b0;
    if (commit_q) begin
      value_d = cval_q;
      ld_win  = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          case (RxData)
            CMD_S: mode_d = MODE_STOP;
            CMD_U: mode_d = MODE_UP;
            CMD_D: mode_d = MODE_DOWN;
            CMD_R: begin
              value_d = '0;
              ld_win  = 1'b1;
            end
            CMD_L: begin
              state_d = ST_LOAD;
              acc_d   = '0;
              ndig_d  = '0;
            end
`ifdef MINI_CALC_3_QUERY_EN
            CMD_Q: state_d = ST_QWAIT;
`endif
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (rx_fire) begin
          if (is_dig) begin
            if (ndig_q < CW'(DIGITS)) begin
              acc_d = acc_q * DATA_WIDTH'(10)
                    + DATA_WIDTH'(RxData[3:0]);
              ndig_d = ndig_q + 1'b1;
            end
          end else if (RxData == CMD_CR) begin
            commit_d = 1'b1;
            cval_d   = (acc_q > MAXV) ? MAXV : acc_q;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`ifdef MINI_CALC_3_QUERY_EN
      ST_QWAIT: begin
        if (cv_done)
          state_d = ST_QSEND;
      end
      ST_QSEND: begin
        if (TxValid && TxReady && TxData == CMD_LF)
          state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // A load or clear in the same cycle swallows the tick
    if (!ld_win && Tick) begin
      unique case (mode_q)
        MODE_UP: begin
          if (value_q == MAXV) begin
            lim_d = 1'b1;
            if (WRAP != 0)
              value_d = '0;
          end else begin
            value_d = value_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (value_q == '0) begin
            lim_d = 1'b1;
            if (WRAP != 0)
              value_d = MAXV;
          end else begin
            value_d = value_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    rdy_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_STOP;
      value_q  <= '0;
      acc_q    <= '0;
      ndig_q   <= '0;
      commit_q <= 1'b0;
      cval_q   <= '0;
      lim_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      value_q  <= value_d;
      acc_q    <= acc_d;
      ndig_q   <= ndig_d;
      commit_q <= commit_d;
      cval_q   <= cval_d;
      lim_q    <= lim_d;
      rdy_q    <= rdy_d;
    end
  end

`ifdef MINI_CALC_3_QUERY_EN
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic [CW-1:0]       idx_q;
  logic [4*DIGITS-1:0] sh_q;

  // idx_q counts bytes already accepted; byte DIGITS is the LF
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      idx_q      <= '0;
      sh_q       <= '0;
    end else if (state_q == ST_QWAIT && cv_done) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= to_ascii(Bcd[4*DIGITS-1 -: 4]);
      sh_q       <= Bcd << 4;
      idx_q      <= '0;
    end else if (tx_valid_q && TxReady) begin
      if (idx_q == CW'(DIGITS)) begin
        tx_valid_q <= 1'b0;
        tx_data_q  <= '0;
      end else if (idx_q == CW'(DIGITS - 1)) begin
        tx_data_q <= CMD_LF;
        idx_q     <= idx_q + 1'b1;
      end else begin
        tx_data_q <= to_ascii(sh_q[4*DIGITS-1 -: 4]);
        sh_q      <= sh_q << 4;
        idx_q     <= idx_q + 1'b1;
      end
    end
  end

  assign TxData  = tx_data_q;
  assign TxValid = tx_valid_q;
`else
  logic unused_tx;
  assign unused_tx = TxReady ^ cv_done;
  assign TxData    = '0;
  assign TxValid   = 1'b0;
`endif

  assign RxReady      = rdy_q;
  assign Value        = value_q;
  assign Mode         = mode_q;
  assign LimitReached = lim_q;

endmodule

// File: tb/tb_mini_calc_3.sv
// Directed bench for mini_calc_3: wrapping and saturating instances
// share one stimulus stream.
module tb_mini_calc_3;
  import mini_calc_3_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Tick;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        TxReady;

  logic        rdy_a, rdy_b;
  logic [7:0]  txd_a, txd_b;
  logic        txv_a, txv_b;
  logic [15:0] val_a, val_b;
  logic [15:0] bcd_a, bcd_b;
  logic [1:0]  mode_a, mode_b;
  logic        lim_a, lim_b;

  int checks = 0;
  int errors = 0;
  int nlim_a = 0;
  int nlim_b = 0;
  int base_a, base_b;
  logic [63:0] frame;
  int nbytes, rbad;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (lim_a) nlim_a++;
    if (lim_b) nlim_b++;
  end

  mini_calc_3 #(.WRAP(1)) u_dut (
    .Clk(Clk), .Reset(Reset), .Tick(Tick),
    .RxData(RxData), .RxValid(RxValid), .RxReady(rdy_a),
    .TxData(txd_a), .TxValid(txv_a), .TxReady(TxReady),
    .Value(val_a), .Bcd(bcd_a), .Mode(mode_a),
    .LimitReached(lim_a)
  );

  mini_calc_3 #(.WRAP(0)) u_sat (
    .Clk(Clk), .Reset(Reset), .Tick(Tick),
    .RxData(RxData), .RxValid(RxValid), .RxReady(rdy_b),
    .TxData(txd_b), .TxValid(txv_b), .TxReady(TxReady),
    .Value(val_b), .Bcd(bcd_b), .Mode(mode_b),
    .LimitReached(lim_b)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge Clk);
    while (!rdy_a && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!rdy_a) chk("rx_wait", rdy_a, 1);
    RxData  = b;
    RxValid = 1'b1;
    @(negedge Clk);
    RxValid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send(s[i]);
  endtask

  task automatic send_tick(input logic [7:0] b);
    @(negedge Clk);
    chk("rdy_pre", rdy_a, 1);
    RxData  = b;
    RxValid = 1'b1;
    Tick    = 1'b1;
    @(negedge Clk);
    RxValid = 1'b0;
    Tick    = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge Clk);
      Tick = 1'b1;
      @(negedge Clk);
      Tick = 1'b0;
    end
  endtask

  task automatic get_frame(output logic [63:0] f,
                           output int nb,
                           output int bad);
    int cyc;
    bit t;
    f   = '0;
    nb  = 0;
    bad = 0;
    cyc = 0;
    t   = 1'b1;
    while (nb < 5 && cyc < 400) begin
      @(negedge Clk);
      TxReady = t;
      t = !t;
      cyc++;
      if (rdy_a) bad++;
      if (txv_a && TxReady) begin
        f = {f[55:0], txd_a};
        nb++;
      end
    end
    @(negedge Clk);
    TxReady = 1'b0;
  endtask

  initial begin
    Reset   = 1'b0;
    Tick    = 1'b0;
    RxValid = 1'b0;
    RxData  = '0;
    TxReady = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_value", val_a, 0);
    chk("rst_mode", mode_a, 0);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_lim", lim_a, 0);
    chk("rst_txv", txv_a, 0);
    chk("rst_txd", txd_a, 0);
    chk("rst_rdy", rdy_a, 0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rdy_rise", rdy_a, 1);

    send(CMD_U);
    ticks(5);
    @(negedge Clk);
    chk("up5_value", val_a, 5);
    chk("up5_mode", mode_a, 1);
    repeat (34) @(negedge Clk);
    chk("up5_bcd", bcd_a, 16'h0005);

    send_str("L9999");
    send(CMD_CR);
    repeat (2) @(negedge Clk);
    chk("ld9999_a", val_a, 9999);
    chk("ld9999_b", val_b, 9999);
    base_a = nlim_a;
    base_b = nlim_b;
    ticks(1);
    repeat (2) @(negedge Clk);
    chk("wrap_up_val", val_a, 0);
    chk("wrap_up_lim", nlim_a - base_a, 1);
    chk("sat_up_val", val_b, 9999);
    chk("sat_up_lim", nlim_b - base_b, 1);

    send_str("L12345");
    send(CMD_CR);
    repeat (2) @(negedge Clk);
    chk("ld_trunc", val_a, 1234);
    send_str("L99x");
    send_str("7");
    send(CMD_CR);
    repeat (2) @(negedge Clk);
    chk("ld_abort", val_a, 1234);
    send(CMD_L);
    send(CMD_CR);
    repeat (2) @(negedge Clk);
    chk("ld_empty", val_a, 0);

    send(CMD_D);
    base_a = nlim_a;
    base_b = nlim_b;
    ticks(1);
    repeat (2) @(negedge Clk);
    chk("wrap_dn_val", val_a, 9999);
    chk("wrap_dn_lim", nlim_a - base_a, 1);
    chk("sat_dn_val", val_b, 0);
    chk("sat_dn_lim", nlim_b - base_b, 1);

    base_a = nlim_a;
    base_b = nlim_b;
    send_str("L123");
    @(negedge Clk);
    RxData  = CMD_CR;
    RxValid = 1'b1;
    @(negedge Clk);
    RxValid = 1'b0;
    Tick    = 1'b1;
    @(negedge Clk);
    Tick    = 1'b0;
    repeat (2) @(negedge Clk);
    chk("ldtick_a", val_a, 123);
    chk("ldtick_b", val_b, 123);
    chk("ldtick_lim", nlim_a - base_a, 0);
    chk("ldtick_limb", nlim_b - base_b, 0);

    send_tick(CMD_R);
    @(negedge Clk);
    chk("rtick_val", val_a, 0);
    chk("rtick_lim", nlim_a - base_a, 0);

    base_a = nlim_a;
    send_tick(CMD_U);
    repeat (2) @(negedge Clk);
    chk("modetick_a", val_a, 9999);
    chk("modetick_b", val_b, 0);
    chk("modetick_lim", nlim_a - base_a, 1);
    chk("modetick_mode", mode_a, 1);

    send(CMD_S);
    ticks(3);
    @(negedge Clk);
    chk("stop_val", val_a, 9999);
    chk("stop_mode", mode_a, 0);

    send_str("L42");
    send(CMD_CR);
    repeat (40) @(negedge Clk);
    chk("bcd42", bcd_a, 16'h0042);

`ifdef MINI_CALC_3_QUERY_EN
    send(CMD_Q);
    get_frame(frame, nbytes, rbad);
    chk("q42_count", nbytes, 5);
    chk("q42_frame", frame[39:0], 40'h303034320A);
    chk("q42_rdylow", rbad, 0);
    chk("q42_txv_end", txv_a, 0);
    chk("q42_rdy_end", rdy_a, 1);

    send(CMD_Q);
    nbytes = 0;
    while (!txv_a && nbytes < 100) begin
      @(negedge Clk);
      nbytes++;
    end
    chk("qs_txv_up", txv_a, 1);
    Reset = 1'b0;
    #1;
    chk("qs_rst_txv", txv_a, 0);
    chk("qs_rst_txd", txd_a, 0);
    chk("qs_rst_val", val_a, 0);
    chk("qs_rst_bcd", bcd_a, 0);
    chk("qs_rst_rdy", rdy_a, 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (40) @(negedge Clk);
    send(CMD_Q);
    get_frame(frame, nbytes, rbad);
    chk("q0_count", nbytes, 5);
    chk("q0_frame", frame[39:0], 40'h303030300A);
`else
    TxReady = 1'b1;
    send(CMD_Q);
    repeat (40) @(negedge Clk);
    chk("noq_txv", txv_a, 0);
    chk("noq_txd", txd_a, 0);
    chk("noq_rdy", rdy_a, 1);
    TxReady = 1'b0;
    Reset = 1'b0;
    #1;
    chk("async_val", val_a, 0);
    chk("async_rdy", rdy_a, 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
